fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, power of two >= 2: instruction queue entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (low = in reset).
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_resp_valid  input  1  returned instruction valid.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port inst_valid  output  1  queue head valid toward decode.
REQ-011 SHALL have port inst_data  output  32  queue head instruction.
REQ-012 SHALL have port inst_pc  output  32  address of queue head instruction.
REQ-013 SHALL have port inst_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port redirect_valid  input  1  taken branch/jal/jalr: refetch.
REQ-015 SHALL have port redirect_pc  input  32  new fetch address.
REQ-016 SHALL have port halt  input  1  level; stop issuing new requests (ecall halt).

Function
REQ-017 SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc,instr}, and FSM states IDLE, WAIT, WAIT_SQUASH.
REQ-018 SHALL allow at most one outstanding memory request.
REQ-019 SHALL drive imem_req_valid = (state==IDLE) & !redirect_valid & !halt & (count < DEPTH); imem_req_addr = fetch_pc.
REQ-020 On imem_req_valid & imem_req_ready: SHALL latch req_pc = fetch_pc, fetch_pc += 4 (mod 2^32, wraps to 0), IDLE -> WAIT.
REQ-021 imem_req_valid, once asserted, SHALL hold with stable address until accepted unless redirect_valid or halt asserts.
REQ-022 In WAIT with imem_resp_valid: SHALL push {req_pc, imem_resp_data}, WAIT -> IDLE.
REQ-023 In WAIT_SQUASH with imem_resp_valid: SHALL discard data, WAIT_SQUASH -> IDLE.
REQ-024 imem_resp_valid in IDLE SHALL be ignored.
REQ-025 inst_valid = (count != 0); inst_data/inst_pc = head entry; pop on inst_valid & inst_ready.
REQ-026 Push and pop in same cycle SHALL leave count unchanged; full queue SHALL never overflow (REQ-019 guarantees slot).
REQ-027 redirect_valid SHALL, next edge: empty the queue, set fetch_pc = {redirect_pc[31:2],2'b00}, WAIT -> WAIT_SQUASH, WAIT_SQUASH stays, IDLE stays.
REQ-028 redirect_valid SHALL take priority over same-cycle pop and same-cycle response (response dropped, state -> IDLE if it completed the squash).
REQ-029 halt SHALL not flush queue or cancel in-flight request; in-flight response still pushed; deassert resumes from fetch_pc.
REQ-030 Latency: request accept at edge N, response in cycle N+k -> inst_valid at edge N+k+1; peak throughput one instruction per 2 cycles.

Reset
REQ-031 reset low SHALL asynchronously set state=IDLE, count=0, fetch_pc=RESET_PC, req_pc=RESET_PC, clearing any squash.
REQ-032 While reset low: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0; imem_req_addr=RESET_PC.
REQ-033 First request SHALL appear in the first cycle after reset deasserts, address RESET_PC.
REQ-034 Reset mid-transaction SHALL drop the outstanding request; a later stray imem_resp_valid SHALL be ignored (REQ-024).

Verification
REQ-035 Reset release, ready=1, 1-cycle response returning 0x00000013, inst_ready=1 -> pcs 0,4,8 presented in order, one per 2 cycles.
REQ-036 inst_ready=0, memory always ready -> exactly DEPTH(2) entries queued (pc 0,4), imem_req_valid drops; inst_ready=1 one cycle -> pc 0 popped, request for 8 issues.
REQ-037 Request pc 4 outstanding, redirect_valid with redirect_pc=0x103 -> response for 4 discarded, next request addr 0x100, queue empty meanwhile.
REQ-038 Redirect same cycle as response and pop -> no push, no pop effect, queue empty, next request at redirect target.
REQ-039 halt=1 with request outstanding -> response pushed, no further requests; halt=0 -> request at next sequential pc.
REQ-040 fetch_pc=0xFFFFFFFC accepted -> next request addr 0x00000000; reset low mid-WAIT -> outputs per REQ-032 immediately, asynchronous to clk.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a small {pc,instr}
// queue toward decode, redirect squashing and a level-sensitive halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_SQUASH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_pc;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Requests are masked while in reset so nothing leaks out before the first edge.
  assign imem_req_valid = reset & (state == IDLE) & ~redirect_valid & ~halt &
                          (count < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

  // A redirect wins over both the response write and the decode pop.
  assign push = (state == WAIT) & imem_resp_valid & ~redirect_valid;
  assign pop  = inst_valid & inst_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_next = IDLE;
        end else if (redirect_valid) begin
          state_next = WAIT_SQUASH;
        end
      end
      WAIT_SQUASH: begin
        if (imem_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire) begin
        req_pc <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      data_mem[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an abstract fetch-stream model feeds a scoreboard
// that a negedge monitor checks against the decode-side and memory-side outputs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  int n_checks   = 0;
  int n_fail     = 0;
  int pops_seen  = 0;

  int ready_pct  = 100;
  int iready_pct = 100;
  int redir_pct  = 0;
  int halt_pct   = 0;
  int stray_pct  = 0;
  int max_lat    = 0;
  bit          redir_once    = 1'b0;
  logic [31:0] redir_once_pc = 32'h0;

  logic [31:0] mem_q[$];
  int          mem_wait = 0;

  entry_t      sb_q[$];
  logic [31:0] model_pc    = RESET_PC;
  logic [31:0] out_pc      = RESET_PC;
  bit          outstanding = 1'b0;
  bit          squashed    = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory side: remember every accepted address so the driver can answer it later.
  always @(negedge clk) begin
    if (!reset) begin
      mem_q.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
    end
  end

  // Reference model plus monitor, evaluated on the inputs that the next edge will see.
  always @(negedge clk) begin : monitor
    logic exp_req;
    if (!reset) begin
      check_output("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check_output("rst_req_addr", imem_req_addr, RESET_PC);
      check_output("rst_inst_valid", 32'(inst_valid), 32'h0);
      check_output("rst_inst_data", inst_data, 32'h0);
      check_output("rst_inst_pc", inst_pc, 32'h0);
      sb_q.delete();
      outstanding = 1'b0;
      squashed    = 1'b0;
      model_pc    = RESET_PC;
    end else begin
      exp_req = !outstanding && !redirect_valid && !halt && (sb_q.size() < DEPTH);
      check_output("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) begin
        check_output("req_addr", imem_req_addr, model_pc);
      end
      check_output("inst_valid", 32'(inst_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        check_output("inst_pc", inst_pc, sb_q[0].pc);
        check_output("inst_data", inst_data, sb_q[0].data);
      end
      if (redirect_valid) begin
        sb_q.delete();
        if (outstanding) begin
          if (imem_resp_valid) begin
            outstanding = 1'b0;
            squashed    = 1'b0;
          end else begin
            squashed = 1'b1;
          end
        end
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (sb_q.size() != 0 && inst_ready) begin
          void'(sb_q.pop_front());
          pops_seen++;
        end
        if (outstanding && imem_resp_valid) begin
          if (!squashed) begin
            sb_q.push_back('{pc: out_pc, data: mem_word(out_pc)});
          end
          outstanding = 1'b0;
          squashed    = 1'b0;
        end
        if (exp_req && imem_req_ready) begin
          outstanding = 1'b1;
          out_pc      = model_pc;
          model_pc    = model_pc + 32'd4;
        end
      end
    end
  end

  task automatic apply_stimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      inst_ready     = ($urandom_range(99) < iready_pct);
      redirect_valid = ($urandom_range(99) < redir_pct);
      redirect_pc    = $urandom;
      if (redir_once) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_once_pc;
        redir_once     = 1'b0;
      end
      if ($urandom_range(99) < halt_pct) begin
        halt = ~halt;
      end
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_q.size() != 0) begin
        if (mem_wait == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_q.pop_front());
          mem_wait        = $urandom_range(max_lat);
        end else begin
          mem_wait--;
        end
      end else if ($urandom_range(99) < stray_pct) begin
        imem_resp_valid = 1'b1;
      end
    end
  endtask

  task automatic set_knobs(input int rdy, input int irdy, input int redir, input int hlt,
                           input int stray, input int lat);
    ready_pct  = rdy;
    iready_pct = irdy;
    redir_pct  = redir;
    halt_pct   = hlt;
    stray_pct  = stray;
    max_lat    = lat;
  endtask

  initial begin
    int tries;
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    halt            = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Streaming with an always-ready memory and decode.
    set_knobs(100, 100, 0, 0, 0, 0);
    apply_stimulus(40);

    // Decode stalls so the queue fills, then drains one entry.
    set_knobs(100, 0, 0, 0, 0, 0);
    apply_stimulus(12);
    set_knobs(100, 100, 0, 0, 0, 0);
    apply_stimulus(1);
    set_knobs(100, 0, 0, 0, 0, 0);
    apply_stimulus(6);

    set_knobs(70, 60, 6, 5, 10, 3);
    apply_stimulus(3000);
    halt = 1'b0;

    // Unaligned redirect near the top of the address space to exercise wraparound.
    set_knobs(100, 100, 0, 0, 0, 0);
    redir_once    = 1'b1;
    redir_once_pc = 32'hFFFF_FFF7;
    apply_stimulus(20);

    // Asynchronous reset while a request is in flight.
    set_knobs(100, 100, 0, 0, 0, 3);
    tries = 0;
    do begin
      apply_stimulus(1);
      tries++;
    end while (mem_q.size() == 0 && tries < 50);
    if (mem_q.size() == 0) begin
      check_output("find_inflight", 32'h0, 32'h1);
    end
    #2 reset = 1'b0;
    #1;
    check_output("async_req_valid", 32'(imem_req_valid), 32'h0);
    check_output("async_req_addr", imem_req_addr, RESET_PC);
    check_output("async_inst_valid", 32'(inst_valid), 32'h0);
    check_output("async_inst_data", inst_data, 32'h0);
    check_output("async_inst_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    mem_wait        = 0;
    set_knobs(70, 60, 6, 5, 10, 3);
    apply_stimulus(500);

    check_output("pop_activity", 32'(pops_seen > 100), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
